// File: rtl/hazard_ctrl.sv
// hazard_ctrl: producer-side hazard controller for the 5-stage core.
// It decides, every cycle, which pipeline registers advance, which are
// turned into bubbles, and whether the PC moves. It covers the three
// hazards that forwarding cannot bypass:
//   - a data-memory access in MEM that has not been acknowledged (freeze),
//   - a taken branch/jump resolved in EX (wrong-path squash),
//   - a load in EX whose result is needed by the instruction in ID.
// A watchdog bounds the memory wait. A free-running counter records how
// many cycles the front end was held.
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_memread,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_bubble,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Wait counter is wide enough to hold MEM_TIMEOUT-1, its terminal value.
    localparam int                WCNT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;

    logic in_run;
    logic in_wait;
    logic wait_start;
    logic wait_expire;
    logic freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Decode the current memory-handshake situation.
    always_comb begin
        in_run      = (state == RUN);
        in_wait     = (state == MEM_WAIT);
        // A request that is not acknowledged in its first cycle opens a wait.
        wait_start  = in_run & mem_req & ~mem_ack;
        // The watchdog fires on the last allowed wait cycle without an ack;
        // that cycle is released rather than frozen.
        wait_expire = in_wait & ~mem_ack & (wcnt == WCNT_MAX);
        freeze      = wait_start | (in_wait & ~mem_ack & (wcnt != WCNT_MAX));
    end

    // Detect a load in EX feeding a register the ID instruction reads.
    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    always_comb begin
        rs1_hit  = id_use_rs1 & (id_rs1 == id_ex_rd);
        rs2_hit  = id_use_rs2 & (id_rs2 == id_ex_rd);
        load_use = id_ex_memread & (id_ex_rd != '0) & (rs1_hit | rs2_hit);
    end

    // Next-state and wait-counter logic for the memory-wait FSM.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                wcnt_nxt = '0;
                if (wait_start) begin
                    state_nxt = MEM_WAIT;
                    // The first stalled cycle has already elapsed on entry.
                    wcnt_nxt  = WCNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (mem_ack || wait_expire) begin
                    // Normal completion or forced release: either way the
                    // pipeline resumes and the counter starts fresh.
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCNT_ONE;
                end
            end
            default: begin
                // Unused encodings recover to RUN.
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end
        endcase
    end

    // FSM state and wait counter; reset abandons any outstanding wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Pipeline enables and flushes, highest-priority hazard first.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            // While in reset nothing advances and every stage holds a bubble.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_en      = 1'b0;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            // Hold every register upstream of MEM/WB. No flushes here, so a
            // taken branch sitting in EX survives the freeze and is acted on
            // in the cycle the memory releases.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else begin
            if (ex_branch_taken) begin
                // IF and ID hold wrong-path instructions; any load-use
                // match against them is meaningless.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                // One-cycle stall: hold IF/ID and PC, insert a bubble into
                // EX, let the load move on to MEM where forwarding reaches it.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
            if (wait_expire) begin
                // The abandoned access returned no valid data; keep it out
                // of the register file.
                mem_wb_bubble = 1'b1;
            end
        end
    end

    // One-cycle pulse reporting a watchdog-forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else begin
            mem_timeout <= wait_expire;
        end
    end

    // Count every cycle the PC was held; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_en) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4). Each step drives the
// inputs, pushes the expected control vector and stall count into a queue,
// and pops/compares it at the following falling edge.
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    // Control vector bit order:
    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_timeout}
    localparam logic [7:0] V_NORMAL  = 8'b1101_0100;
    localparam logic [7:0] V_RESET   = 8'b0010_1010;
    localparam logic [7:0] V_LOADUSE = 8'b0001_1100;
    localparam logic [7:0] V_BRANCH  = 8'b1111_1100;
    localparam logic [7:0] V_FREEZE  = 8'b0000_0010;
    localparam logic [7:0] V_RELEASE = 8'b1101_0110;
    localparam logic [7:0] V_TOPULSE = 8'b1101_0101;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_ex_rd;
    logic              id_use_rs1, id_use_rs2, id_ex_memread;
    logic              ex_branch_taken, mem_req, mem_ack;
    logic              pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic              ex_mem_en, mem_wb_bubble, mem_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] model_stall = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt)
    );

    function automatic logic [7:0] observed();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_bubble, mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Pop the oldest expectation and compare against the DUT outputs now.
    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_ctl"}, {24'd0, observed()}, {24'd0, e.ctl});
            check({e.tag, "_cnt"}, stall_cnt, e.cnt);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic u1, input logic [4:0] r2, input logic u2,
                         input logic br, input logic rq, input logic ak);
        id_ex_memread   = mr;
        id_ex_rd        = rd;
        id_rs1          = r1;
        id_use_rs1      = u1;
        id_rs2          = r2;
        id_use_rs2      = u2;
        ex_branch_taken = br;
        mem_req         = rq;
        mem_ack         = ak;
    endtask

    // One clock cycle: drive, predict, sample mid-cycle, advance the model.
    task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic br, input logic rq,
                        input logic ak, input logic [7:0] exp_ctl);
        exp_t e;
        drive(mr, rd, r1, u1, r2, u2, br, rq, ak);
        e.tag = tag;
        e.ctl = exp_ctl;
        e.cnt = model_stall;
        sb.push_back(e);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        if (!exp_ctl[7]) model_stall++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        e.tag = "reset"; e.ctl = V_RESET; e.cnt = 0;
        sb.push_back(e);
        compare_head();
        @(posedge clk);
        #1 rst_n = 1'b1;

        //    tag              mr rd r1 u1 r2 u2 br rq ak  expected
        step("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, V_NORMAL);
        step("lu_rs2",         1, 5, 0, 0, 5, 1, 0, 0, 0, V_LOADUSE);
        step("lu_after",       0, 5, 0, 0, 5, 1, 0, 0, 0, V_NORMAL);
        step("x0_nohaz",       1, 0, 0, 1, 0, 1, 0, 0, 0, V_NORMAL);
        step("unused_rs1",     1, 5, 5, 0, 7, 0, 0, 0, 0, V_NORMAL);
        step("lu_rs1",         1, 9, 9, 1, 3, 1, 0, 0, 0, V_LOADUSE);
        step("br_over_lu",     1, 5, 5, 1, 5, 1, 1, 0, 0, V_BRANCH);
        step("zero_wait",      0, 0, 0, 0, 0, 0, 0, 1, 1, V_NORMAL);
        step("wait1",          0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("wait2",          0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("wait3",          0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("wait_ack",       0, 0, 0, 0, 0, 0, 0, 1, 1, V_NORMAL);
        step("back_run",       0, 0, 0, 0, 0, 0, 0, 0, 0, V_NORMAL);
        step("frz_br1",        0, 0, 0, 0, 0, 0, 1, 1, 0, V_FREEZE);
        step("frz_br2",        0, 0, 0, 0, 0, 0, 1, 1, 0, V_FREEZE);
        step("frz_br_ack",     0, 0, 0, 0, 0, 0, 1, 1, 1, V_BRANCH);
        step("wd_1",           0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("wd_2",           0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("wd_3",           0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("wd_release",     0, 0, 0, 0, 0, 0, 0, 1, 0, V_RELEASE);
        step("wd_pulse",       0, 0, 0, 0, 0, 0, 0, 0, 0, V_TOPULSE);
        step("wd_pulse_end",   0, 0, 0, 0, 0, 0, 0, 0, 0, V_NORMAL);
        step("rw_1",           0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);
        step("rw_2",           0, 0, 0, 0, 0, 0, 0, 1, 0, V_FREEZE);

        // Reset asserted between clock edges while waiting on memory.
        #2 rst_n = 1'b0;
        #1;
        model_stall = 0;
        e.tag = "async_rst"; e.ctl = V_RESET; e.cnt = 0;
        sb.push_back(e);
        compare_head();
        mem_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, V_NORMAL);
        step("post_rst_lu",    1, 4, 4, 1, 0, 0, 0, 0, 0, V_LOADUSE);
        step("post_rst_cnt",   0, 0, 0, 0, 0, 0, 0, 0, 0, V_NORMAL);

        total++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
